// File: rtl/mul88_seq_ctrl.sv
// 8x8 multiplier sequencer: drives one external 8x4 core twice per operand pair
// and merges the two partial products into a registered 17-bit result.
module mul88_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [7:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [11:0] mul_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] R,
    output logic        busy,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [16:0] r_acc;
    logic [16:0] r_r;
    logic        r_out_valid;
    logic        r_busy;
    logic [15:0] r_op_count;

    logic [16:0] w_sum;

    // The only input-to-output combinational path: DONE frees up as soon as the consumer takes R.
    assign in_ready = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));

    assign w_sum = r_acc + {1'b0, mul_r, 4'b0};

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (r_state)
            S_LOW: begin
                mul_a = r_a;
                mul_b = r_b[3:0];
            end
            S_HIGH: begin
                mul_a = r_a;
                mul_b = r_b[7:4];
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_r         <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_busy  <= 1'b1;
                        r_state <= S_LOW;
                    end
                end
                S_LOW: begin
                    r_acc   <= {5'b0, mul_r};
                    r_state <= S_HIGH;
                end
                S_HIGH: begin
                    r_r         <= w_sum;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_op_count  <= r_op_count + 16'd1;
                        if (in_valid) begin
                            r_a     <= A;
                            r_b     <= B;
                            r_state <= S_LOW;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign R         = r_r;
    assign busy      = r_busy;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_mul88_seq_ctrl.sv
// Self-checking bench for mul88_seq_ctrl with a behavioural 8x4 core (exact or stuck at 0xFFF)
// and a scoreboard of expected results keyed by input handshakes.
module tb_mul88_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [7:0]  mul_a;
    logic [3:0]  mul_b;
    logic [11:0] mul_r;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] R;
    logic        busy;
    logic [15:0] op_count;

    bit          approx = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cycle = 0;
    logic [15:0] exp_ops = '0;
    logic [16:0] sb_q[$];

    mul88_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_r     (mul_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [11:0] core_model(input logic [7:0] a, input logic [3:0] b);
        logic [11:0] p;
        p = {4'b0, a} * {8'b0, b};
        return approx ? 12'hFFF : p;
    endfunction

    assign mul_r = core_model(mul_a, mul_b);

    // Expected R: low partial product plus high partial product shifted by four.
    function automatic logic [16:0] expected_r(input logic [7:0] a, input logic [7:0] b);
        logic [16:0] lo;
        logic [16:0] hi;
        lo = {5'b0, core_model(a, b[3:0])};
        hi = {5'b0, core_model(a, b[7:4])};
        return lo + (hi << 4);
    endfunction

    // Scoreboard: push on accepted operands, pop and compare on result handshakes.
    always @(negedge clk) begin
        logic [16:0] exp_v;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected_result: got R=%h with no operand pending", R);
                end else begin
                    exp_v = sb_q.pop_front();
                    if (R !== exp_v) begin
                        n_errors++;
                        $display("FAIL sb_result: got R=%h expected %h", R, exp_v);
                    end
                end
            end
            if (in_valid && in_ready) sb_q.push_back(expected_r(A, B));
        end
    end

    task automatic wait_out(input int budget, output bit found);
        found = 1'b0;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ops = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; A = 8'h55; B = 8'h66; out_ready = 1'b0;
        exp_ops = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({in_ready, out_valid, busy, R, op_count, mul_a, mul_b} !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs: got rdy=%b ov=%b busy=%b R=%h cnt=%h ma=%h mb=%h expected all 0",
                         in_ready, out_valid, busy, R, op_count, mul_a, mul_b);
            end
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || op_count !== 16'h0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got rdy=%b cnt=%h busy=%b expected 1 0000 0", in_ready, op_count, busy);
        end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        A = 8'hFF; B = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL single_accept: got in_ready=%b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; A = 8'h00; B = 8'h00;
        @(negedge clk);
        n_checks++;
        if (mul_a !== 8'hFF || mul_b !== 4'hF || out_valid !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_low: got ma=%h mb=%h ov=%b busy=%b expected ff f 0 1", mul_a, mul_b, out_valid, busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (mul_a !== 8'hFF || mul_b !== 4'hF || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_high: got ma=%h mb=%h ov=%b expected ff f 0", mul_a, mul_b, out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || R !== 17'h0FE01 || R[16] !== 1'b0 || mul_a !== 8'h00 || mul_b !== 4'h0) begin
            n_errors++;
            $display("FAIL single_result: got ov=%b R=%h ma=%h mb=%h expected 1 0fe01 00 0", out_valid, R, mul_a, mul_b);
        end
        exp_ops = exp_ops + 16'd1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || op_count !== exp_ops || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL single_after: got ov=%b cnt=%h rdy=%b busy=%b expected 0 %h 1 0",
                     out_valid, op_count, in_ready, busy, exp_ops);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  pa [3];
        logic [7:0]  pb [3];
        logic [16:0] pr [3];
        logic [16:0] out_r [3];
        int          out_cyc [3];
        int          acc_n;
        int          out_n;
        bit          hs;
        pa = '{8'h12, 8'h00, 8'h80};
        pb = '{8'h34, 8'hAB, 8'h02};
        pr = '{17'h003A8, 17'h00000, 17'h00100};
        acc_n = 0; out_n = 0;
        @(posedge clk); #1;
        A = pa[0]; B = pb[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 30 && out_n < 3; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                out_cyc[out_n] = cycle;
                out_r[out_n]   = R;
                out_n++;
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) begin
                acc_n++;
                if (acc_n < 3) begin
                    A = pa[acc_n]; B = pb[acc_n];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        n_checks++;
        if (out_n != 3) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d results expected 3 within cycle budget", out_n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (out_r[i] !== pr[i]) begin
                    n_errors++;
                    $display("FAIL b2b_result%0d: got R=%h expected %h", i, out_r[i], pr[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (out_cyc[i] - out_cyc[i-1] != 3) begin
                    n_errors++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles expected 3", i, out_cyc[i] - out_cyc[i-1]);
                end
            end
        end
        exp_ops = exp_ops + 16'd3;
        @(negedge clk);
        n_checks++;
        if (op_count !== exp_ops || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_op_count: got cnt=%h ov=%b expected %h 0", op_count, out_valid, exp_ops);
        end
    endtask

    task automatic test_backpressure();
        bit found;
        @(posedge clk); #1;
        A = 8'h0F; B = 8'h10; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        A = 8'h07; B = 8'h03;
        wait_out(6, found);
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL bp_timeout: got no out_valid expected one within 6 cycles");
        end
        for (int c = 0; c < 5; c++) begin
            if (c != 0) begin
                @(posedge clk); #1;
                @(negedge clk);
            end
            n_checks++;
            if (out_valid !== 1'b1 || R !== 17'h000F0 || in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold%0d: got ov=%b R=%h rdy=%b expected 1 000f0 0", c, out_valid, R, in_ready);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_release: got rdy=%b ov=%b expected 1 1", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; A = 8'h00; B = 8'h00;
        wait_out(6, found);
        n_checks++;
        if (!found || R !== 17'h00015) begin
            n_errors++;
            $display("FAIL bp_second: got found=%b R=%h expected 1 00015", found, R);
        end
        exp_ops = exp_ops + 16'd2;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (op_count !== exp_ops) begin
            n_errors++;
            $display("FAIL bp_op_count: got %h expected %h", op_count, exp_ops);
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        apply_reset();
        @(posedge clk); #1;
        A = 8'h44; B = 8'h5A; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || mul_b !== 4'hA) begin
            n_errors++;
            $display("FAIL mid_low: got busy=%b mb=%h expected 1 a", busy, mul_b);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mul_b !== 4'h5 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_high: got mb=%h rdy=%b expected 5 0", mul_b, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || op_count !== exp_ops) begin
            n_errors++;
            $display("FAIL mid_after_reset: got ov=%b busy=%b rdy=%b cnt=%h expected 0 0 1 %h",
                     out_valid, busy, in_ready, op_count, exp_ops);
        end
        @(posedge clk); #1;
        A = 8'd3; B = 8'd5; in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(6, found);
        n_checks++;
        if (!found || R !== 17'd15) begin
            n_errors++;
            $display("FAIL mid_next_op: got found=%b R=%0d expected 1 15", found, R);
        end
        exp_ops = exp_ops + 16'd1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (op_count !== exp_ops) begin
            n_errors++;
            $display("FAIL mid_op_count: got %h expected %h", op_count, exp_ops);
        end
    endtask

    task automatic test_approx_wrap();
        bit found;
        @(posedge clk); #1;
        approx = 1'b1;
        force dut.r_op_count = 16'hFFFF;
        #1;
        release dut.r_op_count;
        @(negedge clk);
        n_checks++;
        if (op_count !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL wrap_preload: got %h expected ffff", op_count);
        end
        @(posedge clk); #1;
        A = 8'h12; B = 8'h34; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(6, found);
        n_checks++;
        if (!found || R !== 17'h10FEF || R[16] !== 1'b1) begin
            n_errors++;
            $display("FAIL approx_result: got found=%b R=%h expected 1 10fef", found, R);
        end
        @(posedge clk); #1;
        approx = 1'b0;
        @(negedge clk);
        n_checks++;
        if (op_count !== 16'h0000) begin
            n_errors++;
            $display("FAIL wrap_op_count: got %h expected 0000", op_count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_approx_wrap();
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending results expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
